// File: rtl/ht1632_frame_rx_pkg.sv
// Shared constants and FSM state encoding for the HT1632 write-link receiver.
// The game-side sequence builder imports the same ID and width constants.
package ht1632_frame_rx_pkg;

    localparam int          ID_BITS   = 3;
    localparam int          ADDR_BITS = 7;
    localparam int          DATA_BITS = 384;
    localparam logic [2:0]  ID_CODE   = 3'b101;
    localparam int          ROWS      = 16;
    localparam int          COLS      = 24;

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        ID,
        ADDR,
        DATA,
        DRAIN
    } state_t;

    // Total serial bits in a well-formed write frame.
    function automatic int frameBits(input int addrBits, input int dataBits);
        return ID_BITS + addrBits + dataBits;
    endfunction

endpackage

// File: rtl/ht1632_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with registered rise/fall pulses.
// level_o is the synchronized sample that the rise/fall pulses were computed from.
module ht1632_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // STAGES must be at least 2 for metastability protection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
            prev_q  <= chain_q[STAGES-1];
            rise_q  <= chain_q[STAGES-1] & ~prev_q;
            fall_q  <= ~chain_q[STAGES-1] & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ht1632_frame_rx.sv
// Receive end of the HT1632 cs/write/data link: deserializes one write frame into
// a double-buffered pixel register. Optional readback port: HT1632_RX_READBACK_EN.
module ht1632_frame_rx #(
    parameter int         DATA_BITS   = ht1632_frame_rx_pkg::DATA_BITS,
    parameter int         ADDR_BITS   = ht1632_frame_rx_pkg::ADDR_BITS,
    parameter logic [2:0] ID_CODE     = ht1632_frame_rx_pkg::ID_CODE,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cs_i,
    input  logic                 write_i,
    input  logic                 data_i,
    output logic [DATA_BITS-1:0] frame_data_o,
    output logic [ADDR_BITS-1:0] frame_addr_o,
    output logic                 frame_valid_o,
    output logic [15:0]          frame_count_o,
    output logic                 err_id_o,
    output logic                 err_len_o,
    output logic                 busy_o
`ifdef HT1632_RX_READBACK_EN
    ,
    input  logic [3:0]           rd_row_i,
    input  logic [4:0]           rd_col_i,
    output logic                 rd_pixel_o
`endif
);

    import ht1632_frame_rx_pkg::*;

    localparam int FRAME_BITS = frameBits(ADDR_BITS, DATA_BITS);
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ID_LAST   = CNT_W'(ID_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ID_BITS + ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT       = CNT_W'(FRAME_BITS + 1);

    logic csLevel;
    logic csRise;
    logic csFall;
    logic wrRise;
    logic unusedWrLevel;
    logic unusedWrFall;

    logic [SYNC_STAGES:0]  dataChain_q;
    logic                  bitIn;

    state_t                state_q;
    logic [CNT_W-1:0]      bitCount_q;
    logic [CNT_W-1:0]      bitCount_d;
    logic [ID_BITS-1:0]    idShift_q;
    logic [ID_BITS-1:0]    idShift_d;
    logic [ADDR_BITS-1:0]  addrShift_q;
    logic [ADDR_BITS-1:0]  addrShift_d;
    logic [DATA_BITS-1:0]  dataShift_q;
    logic [DATA_BITS-1:0]  dataShift_d;
    logic                  idBad_q;

    logic [DATA_BITS-1:0]  frameData_q;
    logic [ADDR_BITS-1:0]  frameAddr_q;
    logic                  frameValid_q;
    logic [15:0]           frameCount_q;
    logic                  errId_q;
    logic                  errLen_q;

    ht1632_sync_edge #(.STAGES(SYNC_STAGES)) u_csSync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (cs_i),
        .level_o(csLevel),
        .rise_o (csRise),
        .fall_o (csFall)
    );

    ht1632_sync_edge #(.STAGES(SYNC_STAGES)) u_wrSync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (write_i),
        .level_o(unusedWrLevel),
        .rise_o (wrRise),
        .fall_o (unusedWrFall)
    );

    // One stage longer than the strobe synchronizer so bitIn lines up with wrRise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dataChain_q <= '0;
        end else begin
            dataChain_q <= {dataChain_q[SYNC_STAGES-1:0], data_i};
        end
    end

    assign bitIn = dataChain_q[SYNC_STAGES];

    always_comb begin
        bitCount_d  = (bitCount_q == CNT_SAT) ? bitCount_q : bitCount_q + 1'b1;
        idShift_d   = {idShift_q[ID_BITS-2:0], bitIn};
        addrShift_d = {addrShift_q[ADDR_BITS-2:0], bitIn};
        dataShift_d = {dataShift_q[DATA_BITS-2:0], bitIn};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ARM;
            bitCount_q   <= '0;
            idShift_q    <= '0;
            addrShift_q  <= '0;
            dataShift_q  <= '0;
            idBad_q      <= 1'b0;
            frameData_q  <= '0;
            frameAddr_q  <= '0;
            frameValid_q <= 1'b0;
            frameCount_q <= '0;
            errId_q      <= 1'b0;
            errLen_q     <= 1'b0;
        end else begin
            frameValid_q <= 1'b0;
            errId_q      <= 1'b0;
            errLen_q     <= 1'b0;
            case (state_q)
                ARM: begin
                    if (csLevel) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (csFall) begin
                        state_q     <= ID;
                        bitCount_q  <= '0;
                        idShift_q   <= '0;
                        addrShift_q <= '0;
                        dataShift_q <= '0;
                        idBad_q     <= 1'b0;
                    end
                end
                ID, ADDR, DATA, DRAIN: begin
                    // A cs rise outranks a write edge seen in the same sample.
                    if (csRise) begin
                        state_q <= IDLE;
                        if ((bitCount_q == CNT_FULL) && !idBad_q) begin
                            frameData_q  <= dataShift_q;
                            frameAddr_q  <= addrShift_q;
                            frameValid_q <= 1'b1;
                            frameCount_q <= frameCount_q + 16'd1;
                        end else begin
                            errId_q  <= idBad_q;
                            errLen_q <= (bitCount_q != CNT_FULL);
                        end
                    end else if (wrRise) begin
                        bitCount_q <= bitCount_d;
                        case (state_q)
                            ID: begin
                                idShift_q <= idShift_d;
                                if (bitCount_q == CNT_ID_LAST) begin
                                    if (idShift_d == ID_CODE) begin
                                        state_q <= ADDR;
                                    end else begin
                                        state_q <= DRAIN;
                                        idBad_q <= 1'b1;
                                    end
                                end
                            end
                            ADDR: begin
                                addrShift_q <= addrShift_d;
                                if (bitCount_q == CNT_ADDR_LAST) begin
                                    state_q <= DATA;
                                end
                            end
                            DATA: begin
                                if (bitCount_q < CNT_FULL) begin
                                    dataShift_q <= dataShift_d;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                default: begin
                    state_q <= ARM;
                end
            endcase
        end
    end

    assign frame_data_o  = frameData_q;
    assign frame_addr_o  = frameAddr_q;
    assign frame_valid_o = frameValid_q;
    assign frame_count_o = frameCount_q;
    assign err_id_o      = errId_q;
    assign err_len_o     = errLen_q;
    assign busy_o        = !csLevel && (state_q inside {ID, ADDR, DATA, DRAIN});

`ifdef HT1632_RX_READBACK_EN
    localparam int IDX_W = $clog2(DATA_BITS);

    int               rdIndex;
    logic             rdInRange;
    logic [IDX_W-1:0] rdBit;
    logic             rdPixel_q;

    always_comb begin
        rdIndex   = int'(rd_row_i) * COLS + int'(rd_col_i);
        rdInRange = (int'(rd_row_i) < ROWS) && (int'(rd_col_i) < COLS) && (rdIndex < DATA_BITS);
        rdBit     = rdInRange ? IDX_W'(DATA_BITS - 1 - rdIndex) : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdPixel_q <= 1'b0;
        end else begin
            rdPixel_q <= rdInRange ? frameData_q[rdBit] : 1'b0;
        end
    end

    assign rd_pixel_o = rdPixel_q;
`endif

endmodule

// File: tb/tb_ht1632_frame_rx.sv
// Self-checking bench for ht1632_frame_rx: directed and randomized frames against a
// frame-level reference model. Readback checks compile in with HT1632_RX_READBACK_EN.
module tb_ht1632_frame_rx;

    localparam int DATA_BITS  = 384;
    localparam int ADDR_BITS  = 7;
    localparam int FRAME_BITS = 3 + ADDR_BITS + DATA_BITS;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cs;
    logic                 write;
    logic                 data;
    logic [DATA_BITS-1:0] frame_data;
    logic [ADDR_BITS-1:0] frame_addr;
    logic                 frame_valid;
    logic [15:0]          frame_count;
    logic                 err_id;
    logic                 err_len;
    logic                 busy;
`ifdef HT1632_RX_READBACK_EN
    logic [3:0]           rd_row = 4'd0;
    logic [4:0]           rd_col = 5'd0;
    logic                 rd_pixel;
`endif

    ht1632_frame_rx dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cs_i         (cs),
        .write_i      (write),
        .data_i       (data),
        .frame_data_o (frame_data),
        .frame_addr_o (frame_addr),
        .frame_valid_o(frame_valid),
        .frame_count_o(frame_count),
        .err_id_o     (err_id),
        .err_len_o    (err_len),
        .busy_o       (busy)
`ifdef HT1632_RX_READBACK_EN
        ,
        .rd_row_i     (rd_row),
        .rd_col_i     (rd_col),
        .rd_pixel_o   (rd_pixel)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int validCnt  = 0;
    int errIdCnt  = 0;
    int errLenCnt = 0;

    bit                   frameQ[$];
    logic [DATA_BITS-1:0] expData;
    logic [ADDR_BITS-1:0] expAddr;
    logic [15:0]          expCount;
    int                   lat;
    logic                 busyMid;

    // Pulse counters let each frame be judged by how many pulses of each kind it produced.
    always @(negedge clk) begin
        if (frame_valid) validCnt++;
        if (err_id) errIdCnt++;
        if (err_len) errLenCnt++;
    end

    task automatic checkOutput(input string tag, input logic [DATA_BITS-1:0] observed,
                               input logic [DATA_BITS-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic buildFrame(input logic [2:0] id, input logic [ADDR_BITS-1:0] addr,
                              input int nData, input bit alternate);
        frameQ.delete();
        for (int i = 2; i >= 0; i--) frameQ.push_back(id[i]);
        for (int i = ADDR_BITS - 1; i >= 0; i--) frameQ.push_back(addr[i]);
        for (int i = 0; i < nData; i++) begin
            if (alternate) frameQ.push_back(i % 2 == 0);
            else frameQ.push_back(bit'($urandom_range(0, 1)));
        end
    endtask

    task automatic sendBit(input bit b);
        data  = b;
        write = 1'b0;
        repeat (2) @(negedge clk);
        write = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Drives frameQ onto the pins; with coincide set, the last write rise lands with cs rise.
    task automatic applyStimulus(input bit coincide);
        int n;
        n = frameQ.size();
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        busyMid = busy;
        for (int i = 0; i < n - (coincide ? 1 : 0); i++) begin
            if (i == 5) busyMid = busy;
            sendBit(frameQ[i]);
        end
        if (coincide) begin
            data  = frameQ[n-1];
            write = 1'b0;
            repeat (2) @(negedge clk);
            write = 1'b1;
            cs    = 1'b1;
        end else begin
            cs = 1'b1;
        end
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid && lat == 0) lat = k;
        end
        write = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic runFrame(input string tag, input bit coincide);
        int       n, nEff, v0, i0, l0;
        logic [2:0] idv;
        bit       good, expErrId, expErrLen;
        n    = frameQ.size();
        nEff = coincide ? n - 1 : n;
        idv  = (nEff >= 3) ? {frameQ[0], frameQ[1], frameQ[2]} : 3'b000;
        good      = (nEff == FRAME_BITS) && (idv == 3'b101);
        expErrId  = (nEff >= 3) && (idv != 3'b101);
        expErrLen = (nEff != FRAME_BITS);
        v0 = validCnt;
        i0 = errIdCnt;
        l0 = errLenCnt;
        applyStimulus(coincide);
        if (good) begin
            for (int i = 0; i < DATA_BITS; i++) expData[DATA_BITS-1-i] = frameQ[10+i];
            for (int i = 0; i < ADDR_BITS; i++) expAddr[ADDR_BITS-1-i] = frameQ[3+i];
            expCount = expCount + 16'd1;
        end
        checkOutput({tag, ".valid"}, DATA_BITS'(validCnt - v0), DATA_BITS'(good ? 1 : 0));
        checkOutput({tag, ".errId"}, DATA_BITS'(errIdCnt - i0), DATA_BITS'(expErrId ? 1 : 0));
        checkOutput({tag, ".errLen"}, DATA_BITS'(errLenCnt - l0), DATA_BITS'(expErrLen ? 1 : 0));
        checkOutput({tag, ".data"}, frame_data, expData);
        checkOutput({tag, ".addr"}, DATA_BITS'(frame_addr), DATA_BITS'(expAddr));
        checkOutput({tag, ".count"}, DATA_BITS'(frame_count), DATA_BITS'(expCount));
        checkOutput({tag, ".latency"}, DATA_BITS'(lat), DATA_BITS'(good ? 4 : 0));
        checkOutput({tag, ".busy"}, DATA_BITS'(busyMid), DATA_BITS'(1));
        checkOutput({tag, ".busyAfter"}, DATA_BITS'(busy), DATA_BITS'(0));
    endtask

    initial begin
        int         v0, i0, l0, kind;
        logic [2:0] badId;

        rst      = 1'b1;
        cs       = 1'b1;
        write    = 1'b0;
        data     = 1'b0;
        expData  = '0;
        expAddr  = '0;
        expCount = '0;
        busyMid  = 1'b0;

        repeat (5) @(negedge clk);
        checkOutput("reset.data", frame_data, '0);
        checkOutput("reset.addr", DATA_BITS'(frame_addr), '0);
        checkOutput("reset.count", DATA_BITS'(frame_count), '0);
        checkOutput("reset.pulses", DATA_BITS'({frame_valid, err_id, err_len}), '0);
        checkOutput("reset.busy", DATA_BITS'(busy), '0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        buildFrame(3'b101, 7'h00, DATA_BITS, 1'b1);
        runFrame("goodAlt", 1'b0);
        checkOutput("goodAlt.pattern", frame_data, {192{2'b10}});

`ifdef HT1632_RX_READBACK_EN
        @(negedge clk);
        rd_row = 4'd0;
        rd_col = 5'd1;
        @(posedge clk);
        #1;
        checkOutput("readback.r0c1", DATA_BITS'(rd_pixel), '0);
        for (int r = 0; r < 6; r++) begin
            int row, col;
            row = int'($urandom_range(0, 15));
            col = int'($urandom_range(0, 31));
            @(negedge clk);
            rd_row = 4'(row);
            rd_col = 5'(col);
            @(posedge clk);
            #1;
            checkOutput($sformatf("readback.r%0dc%0d", row, col), DATA_BITS'(rd_pixel),
                        DATA_BITS'((col < 24) ? expData[DATA_BITS-1-(row*24+col)] : 1'b0));
        end
`endif

        buildFrame(3'b100, 7'h2A, DATA_BITS, 1'b0);
        runFrame("badId", 1'b0);

        buildFrame(3'b101, 7'h05, 200, 1'b0);
        runFrame("short", 1'b0);

        buildFrame(3'b101, 7'h11, 390, 1'b0);
        runFrame("long", 1'b0);

        // Reset held while a frame starts and released with cs still low.
        @(negedge clk);
        rst = 1'b1;
        buildFrame(3'b101, 7'h33, DATA_BITS, 1'b0);
        v0 = validCnt;
        i0 = errIdCnt;
        l0 = errLenCnt;
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 50; i++) sendBit(frameQ[i]);
        rst      = 1'b0;
        expData  = '0;
        expAddr  = '0;
        expCount = '0;
        for (int i = 50; i < frameQ.size(); i++) begin
            if (i == 60) checkOutput("midReset.busy", DATA_BITS'(busy), '0);
            sendBit(frameQ[i]);
        end
        cs = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("midReset.pulses", DATA_BITS'((validCnt - v0) + (errIdCnt - i0) + (errLenCnt - l0)), '0);
        checkOutput("midReset.data", frame_data, expData);
        checkOutput("midReset.count", DATA_BITS'(frame_count), DATA_BITS'(expCount));

        buildFrame(3'b101, 7'h7F, DATA_BITS, 1'b0);
        runFrame("afterReset", 1'b0);

        buildFrame(3'b101, 7'h19, DATA_BITS + 1, 1'b0);
        runFrame("coincident", 1'b1);

        frameQ.delete();
        runFrame("csPulse", 1'b0);

        for (int r = 0; r < 5; r++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                buildFrame(3'b101, 7'($urandom_range(0, 127)), DATA_BITS, 1'b0);
            end else if (kind == 1) begin
                do badId = 3'($urandom_range(0, 7)); while (badId == 3'b101);
                buildFrame(badId, 7'($urandom_range(0, 127)), int'($urandom_range(360, 390)), 1'b0);
            end else begin
                int len;
                do len = int'($urandom_range(0, 392)); while (len == DATA_BITS);
                buildFrame(3'b101, 7'($urandom_range(0, 127)), len, 1'b0);
            end
            runFrame($sformatf("rand%0d", r), 1'b0);
        end

        @(negedge clk);
        force dut.frameCount_q = 16'hFFFF;
        @(negedge clk);
        release dut.frameCount_q;
        expCount = 16'hFFFF;
        buildFrame(3'b101, 7'h40, DATA_BITS, 1'b0);
        runFrame("wrap", 1'b0);
        checkOutput("wrap.zero", DATA_BITS'(frame_count), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
